// File: rtl/fp_addsub_result_stage_if.sv
// Handshake bundle between the FP add/sub unit, the result stage and its consumer.
// The result stage connects through the slave modport; the driver side
// (adder plus consumer) uses the master modport.
interface fp_addsub_result_stage_if #(
  parameter int CNT_W = 8
);
  // producer side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_vout;
  logic [2:0]       in_opcode;
  // consumer side
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_vout;
  logic [2:0]       out_opcode;
  logic [2:0]       out_class;
  // status / debug
  logic             sticky_exc;
  logic             clr_sticky;
  logic [CNT_W-1:0] ovf_count;

  modport slave (
    input  in_valid, in_result, in_vout, in_opcode, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_vout, out_opcode, out_class,
           sticky_exc, ovf_count
  );

  modport master (
    output in_valid, in_result, in_vout, in_opcode, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_vout, out_opcode, out_class,
           sticky_exc, ovf_count
  );
endinterface

// File: rtl/fp_addsub_result_stage.sv
// Registered result stage behind the combinational FP add/sub unit.
// Classifies each accepted result, buffers it in a first-word-fall-through
// FIFO and keeps a sticky exception flag plus a saturating overflow counter.
// Optional build macro FP_RES_FLUSH_DENORM_EN: flush denormal results to
// signed zero at push and flag them as exceptions.
module fp_addsub_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  fp_addsub_result_stage_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] OVF_MAX    = '1;

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_DENORM = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  typedef struct packed {
    logic [31:0] result;
    logic        vout;
    logic [2:0]  opcode;
    logic [2:0]  cls;
  } entry_t;

  entry_t           entry_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             sticky_reg;
  logic             sticky_next;
  logic [CNT_W-1:0] ovf_reg;
  logic [CNT_W-1:0] ovf_next;

  entry_t           entry_in;
  entry_t           head;
  logic             exc_in;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic [7:0]       exp_in;
  logic [22:0]      man_in;

  assign not_empty = (count_reg != '0);
  // Acceptance looks at occupancy only, so a full FIFO refuses a push even
  // when the consumer pops in the same cycle.
  assign push      = bus.in_valid && (count_reg != FULL_COUNT);
  assign pop       = bus.out_ready && not_empty;

  assign exp_in = bus.in_result[30:23];
  assign man_in = bus.in_result[22:0];

  // Classify the incoming word and decide whether it raises the exception flag
  always_comb begin
    entry_in.result = bus.in_result;
    entry_in.vout   = bus.in_vout;
    entry_in.opcode = bus.in_opcode;
    entry_in.cls    = CLS_NORMAL;
    exc_in          = bus.in_vout;
    if (exp_in == 8'd0) begin
      if (man_in == '0) begin
        entry_in.cls = CLS_ZERO;
      end else begin
`ifdef FP_RES_FLUSH_DENORM_EN
        entry_in.result = {bus.in_result[31], 31'b0};
        entry_in.cls    = CLS_ZERO;
        exc_in          = 1'b1;
`else
        entry_in.cls    = CLS_DENORM;
`endif
      end
    end else if (exp_in == 8'hFF) begin
      entry_in.cls = (man_in == '0) ? CLS_INF : CLS_NAN;
      exc_in       = 1'b1;
    end
  end

  // Storage array: written at the tail, never reset (outputs are gated instead)
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr_reg] <= entry_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Sticky flag and overflow counter: a set in the same cycle as a clear wins
  always_comb begin
    sticky_next = sticky_reg;
    ovf_next    = ovf_reg;
    if (bus.clr_sticky) begin
      sticky_next = 1'b0;
      ovf_next    = '0;
    end
    if (push && exc_in) begin
      sticky_next = 1'b1;
    end
    if (push && bus.in_vout) begin
      if (bus.clr_sticky)        ovf_next = CNT_W'(1);
      else if (ovf_reg != OVF_MAX) ovf_next = ovf_reg + 1'b1;
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
      ovf_reg    <= '0;
    end else begin
      sticky_reg <= sticky_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Head entry falls through from the array; forced to zero while empty
  always_comb begin
    head = '0;
    if (not_empty) head = entry_reg[rd_ptr_reg];
  end

  assign bus.in_ready   = (count_reg != FULL_COUNT);
  assign bus.out_valid  = not_empty;
  assign bus.out_result = head.result;
  assign bus.out_vout   = head.vout;
  assign bus.out_opcode = head.opcode;
  assign bus.out_class  = head.cls;
  assign bus.sticky_exc = sticky_reg;
  assign bus.ovf_count  = ovf_reg;

endmodule

// File: tb/tb_fp_addsub_result_stage.sv
// Self-checking bench for fp_addsub_result_stage: queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_fp_addsub_result_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   run_cmp;

  fp_addsub_result_stage_if #(.CNT_W(CNT_W)) bus ();

  fp_addsub_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        v;
    logic [2:0]  op;
    logic [2:0]  c;
    bit          exc;
  } exp_t;

  exp_t q[$];
  bit   m_sticky;
  int   m_ovf;

  // Reference view of what a pushed word must become
  function automatic exp_t model_entry(logic [31:0] w, logic v, logic [2:0] op);
    exp_t e;
    int unsigned ex;
    int unsigned mn;
    ex = int'(w[30:23]);
    mn = int'(w[22:0]);
    e.r = w; e.v = v; e.op = op; e.exc = (v == 1'b1);
    if (ex == 0 && mn == 0)        e.c = 3'd0;
    else if (ex == 0) begin
`ifdef FP_RES_FLUSH_DENORM_EN
      e.r = w & 32'h8000_0000; e.c = 3'd0; e.exc = 1'b1;
`else
      e.c = 3'd1;
`endif
    end
    else if (ex < 255)             e.c = 3'd2;
    else if (mn == 0) begin        e.c = 3'd3; e.exc = 1'b1; end
    else begin                     e.c = 3'd4; e.exc = 1'b1; end
    return e;
  endfunction

  // Model state update on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_sticky = 1'b0;
      m_ovf    = 0;
    end else begin
      bit   do_push;
      bit   do_pop;
      exp_t e;
      do_push = (bus.in_valid === 1'b1) && (q.size() < DEPTH);
      do_pop  = (bus.out_ready === 1'b1) && (q.size() > 0);
      e = model_entry(bus.in_result, bus.in_vout, bus.in_opcode);
      if (do_pop) begin
        $display("[TB] pop  result=%h vout=%0d op=%0d class=%0d", q[0].r, q[0].v, q[0].op, q[0].c);
        void'(q.pop_front());
      end
      if (do_push) begin
        $display("[TB] push result=%h vout=%0d op=%0d", bus.in_result, bus.in_vout, bus.in_opcode);
        q.push_back(e);
      end
      if (bus.clr_sticky === 1'b1) begin
        m_sticky = 1'b0;
        m_ovf    = 0;
      end
      if (do_push && e.exc) m_sticky = 1'b1;
      if (do_push && e.v && m_ovf < OVF_MAX) m_ovf++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] w, logic v, logic [2:0] op);
    bus.in_valid  = 1'b1;
    bus.in_result = w;
    bus.in_vout   = v;
    bus.in_opcode = op;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    run_cmp = 1'b1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_vout = 1'b0; bus.in_opcode = '0;
    bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;

    // Per-cycle comparison of DUT outputs against the model
    fork
      forever begin
        @(negedge clk);
        if (run_cmp) begin
          bit vld;
          vld = (q.size() != 0);
          chk("cyc out_valid", 32'(bus.out_valid), 32'(vld));
          chk("cyc in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
          chk("cyc sticky_exc", 32'(bus.sticky_exc), 32'(m_sticky));
          chk("cyc ovf_count", 32'(bus.ovf_count), 32'(m_ovf));
          chk("cyc out_result", bus.out_result, vld ? q[0].r : 32'h0);
          chk("cyc out_vout", 32'(bus.out_vout), vld ? 32'(q[0].v) : 32'h0);
          chk("cyc out_opcode", 32'(bus.out_opcode), vld ? 32'(q[0].op) : 32'h0);
          chk("cyc out_class", 32'(bus.out_class), vld ? 32'(q[0].c) : 32'h0);
        end
      end
    join_none

    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset in_ready", 32'(bus.in_ready), 32'h1);
    chk("reset ovf_count", 32'(bus.ovf_count), 32'h0);

    // Single result, fall-through one cycle after acceptance
    drive(32'h3FC0_0000, 1'b0, 3'b000);
    step();
    bus.in_valid = 1'b0;
    chk("first out_valid", 32'(bus.out_valid), 32'h1);
    chk("first out_result", bus.out_result, 32'h3FC0_0000);
    chk("first out_class", 32'(bus.out_class), 32'd2);
    chk("first sticky", 32'(bus.sticky_exc), 32'h0);
    step();

    // Fill to DEPTH with the consumer stalled
    bus.out_ready = 1'b0;
    drive(32'h3F80_0000, 1'b0, 3'b000); step();
    drive(32'h4000_0000, 1'b0, 3'b001); step();
    drive(32'h4040_0000, 1'b0, 3'b000); step();
    drive(32'h4080_0000, 1'b0, 3'b001); step();
    chk("full in_ready", 32'(bus.in_ready), 32'h0);
    drive(32'h40A0_0000, 1'b0, 3'b000);
    step(); step();
    chk("full held in_ready", 32'(bus.in_ready), 32'h0);
    chk("full head stable", bus.out_result, 32'h3F80_0000);
    bus.out_ready = 1'b1;
    step();
    chk("after pop in_ready", 32'(bus.in_ready), 32'h1);
    chk("after pop head", bus.out_result, 32'h4000_0000);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    chk("drained out_valid", 32'(bus.out_valid), 32'h0);

    // Infinity with overflow, three times
    repeat (3) begin
      drive(32'h7F80_0000, 1'b1, 3'b000);
      step();
    end
    bus.in_valid = 1'b0; bus.in_vout = 1'b0;
    chk("inf out_class", 32'(bus.out_class), 32'd3);
    chk("inf sticky", 32'(bus.sticky_exc), 32'h1);
    chk("inf ovf_count", 32'(bus.ovf_count), 32'd3);
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    chk("clr sticky", 32'(bus.sticky_exc), 32'h0);
    chk("clr ovf_count", 32'(bus.ovf_count), 32'h0);

    // NaN pushed in the same cycle as a clear: set wins
    bus.clr_sticky = 1'b1;
    drive(32'h7FC0_0000, 1'b0, 3'b001);
    step();
    bus.clr_sticky = 1'b0; bus.in_valid = 1'b0;
    chk("nan sticky set wins", 32'(bus.sticky_exc), 32'h1);
    chk("nan out_class", 32'(bus.out_class), 32'd4);
    step();

    // Overflow push together with a clear leaves the counter at one
    bus.clr_sticky = 1'b1;
    drive(32'h4000_0000, 1'b1, 3'b000);
    step();
    bus.clr_sticky = 1'b0; bus.in_valid = 1'b0; bus.in_vout = 1'b0;
    chk("clr+ovf count", 32'(bus.ovf_count), 32'd1);
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;

    // Smallest positive denormal
    drive(32'h0000_0001, 1'b0, 3'b000);
    step();
    bus.in_valid = 1'b0;
`ifdef FP_RES_FLUSH_DENORM_EN
    chk("denorm result", bus.out_result, 32'h0000_0000);
    chk("denorm class", 32'(bus.out_class), 32'd0);
    chk("denorm sticky", 32'(bus.sticky_exc), 32'h1);
`else
    chk("denorm result", bus.out_result, 32'h0000_0001);
    chk("denorm class", 32'(bus.out_class), 32'd1);
    chk("denorm sticky", 32'(bus.sticky_exc), 32'h0);
`endif
    step();

    // Saturation of the 2-bit overflow counter, unusual opcode passes through
    for (int i = 0; i < 5; i++) begin
      drive(32'h4000_0000 + 32'(i), 1'b1, 3'b111);
      step();
    end
    bus.in_valid = 1'b0; bus.in_vout = 1'b0;
    chk("sat ovf_count", 32'(bus.ovf_count), 32'd3);
    chk("sat opcode", 32'(bus.out_opcode), 32'd7);

    // Asynchronous reset in the middle of traffic
    bus.out_ready = 1'b0;
    drive(32'h3F80_0000, 1'b1, 3'b001); step();
    drive(32'h4040_0000, 1'b0, 3'b000); step();
    #3 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("async rst in_ready", 32'(bus.in_ready), 32'h1);
    chk("async rst sticky", 32'(bus.sticky_exc), 32'h0);
    chk("async rst out_result", bus.out_result, 32'h0);
    bus.in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post rst empty", 32'(bus.out_valid), 32'h0);
    chk("post rst ovf_count", 32'(bus.ovf_count), 32'h0);
    bus.out_ready = 1'b1;
    drive(32'hC000_0000, 1'b0, 3'b001);
    step();
    bus.in_valid = 1'b0;
    chk("post rst push", bus.out_result, 32'hC000_0000);
    step(); step();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
